spart_rx: RTL and testbench
===========================

# spart_rx

Serial receiver for the SPART port: 8N1, LSB first, 16x oversampled. Synchronizes the asynchronous `rxd` line and validates the start bit at mid-bit. Samples each data bit at its centre and presents the byte in a holding register with a data-available flag. It is the receive counterpart of the SPART transmit path and shares the same programmable `baud` divisor convention.

## Interface

**Parameters**
- `DIV_W`, default 16: width of the baud divisor.

**Ports**
- `clk`  input  1: single system clock.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `rxd`  input  1: serial line, asynchronous to `clk`, idle high.
- `baud`  input  DIV_W: oversample divisor. One tick every `baud+1` clocks.
- `rd`  input  1: one-cycle read strobe. Clears `rda`, `framing_err` and `overrun`.
- `rdata`  output  8: last received byte.
- `rda`  output  1: receive data available.
- `framing_err`  output  1: sticky. Stop bit was sampled low.
- `overrun`  output  1: sticky. A byte completed while `rda` was still set.

## Operation

**Input synchronizer**
- `rxd` passes through a 2-flop synchronizer.
- Both flops reset to 1.
- All logic uses the synchronized value `rxs`.

**Tick generator**
- Down-counter loads `baud` at reset.
- At count 0 it emits `tick` for 1 cycle and reloads `baud`; otherwise it decrements.
- A change to `baud` takes effect at the next reload.
- `baud=0` gives a tick every clock.

**State machine** (4-bit oversample counter `os`, 3-bit bit index `bi`)
- IDLE: on a tick with `rxs=0`, clear `os` and go to START.
- START: count ticks. At `os==7` (mid start bit):
  - `rxs=0`: clear `os`, clear `bi`, go to DATA.
  - `rxs=1`: treat as a glitch and return to IDLE.
- DATA: at `os==15` (16 ticks later, mid-bit), shift `rxs` into the shift register MSB (LSB-first reception).
  - `bi==7`: go to STOP (or PARITY when the parity feature is compiled in).
  - Otherwise increment `bi`.
- STOP: at `os==15`, sample the stop bit.
  - Load `rdata` from the shift register and set `rda`.
  - Stop bit 0: set `framing_err`. The data is still loaded.
  - Return to IDLE immediately at mid-stop, so a back-to-back start bit is caught.

**Holding register**
- Completion with `rda` already 1: set `overrun` and overwrite `rdata`.
- `rd` with completion in the same cycle: the completion wins. `rda` stays 1 and `overrun` is not set.
  - Flags produced by this completion (e.g. `framing_err`) are set.
  - Older flags are cleared by `rd`.
- `rd` while `rda=0`: no effect.

## Timing

- Reset values: `rdata=8'h00`, `rda=0`, `framing_err=0`, `overrun=0`, state IDLE, `os=0`, `bi=0`, shift register 0.
- Synchronizer latency: 2 clocks.
- Start detection latency: up to one tick period after the synchronizer.
- Data bit sample point: start edge + (1.5 + k) bit periods, for k=0..7, ±(2 + baud+1) clocks.
- `rda`, `framing_err`, `overrun` and `rdata` update registered, 1 clock after the mid-stop tick.
- `rda` clears the clock after `rd` is high.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial byte is discarded.
- After reset release, a line already low is treated as a start edge at the first tick.

## Configuration

- `SPART_RX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP, sampling one bit at `os==15`.
  - Even parity over the 8 data bits plus the parity bit is required.
  - A mismatch sets a sticky `parity_err` output. It resets to 0, is cleared by `rd`, and completion wins over `rd` as for the other flags.
  - The frame becomes 8E1.
- Macro undefined:
  - No PARITY state and no `parity_err` port.
  - Frame is 8N1 as described above.

## Test plan

- **Basic byte:** `baud=3` (tick/4 clk, bit=64 clk), send 8'hA5 8N1, no `rd`.
  - `rda` rises about 610 clocks after the start edge.
  - `rdata=8'hA5`, `framing_err=0`.
- **Start glitch:** `baud=3`, drive `rxd` low for 20 clocks, then high.
  - State returns to IDLE.
  - `rda` stays 0 and no byte is produced.
- **Framing error:** send 8'h3C with stop bit held 0.
  - `rda=1`, `rdata=8'h3C`, `framing_err=1`.
  - `rd` pulse clears both flags next clock.
- **Overrun:** send 8'h11 then 8'h22 back-to-back, no `rd`.
  - `rdata=8'h22`, `rda=1`, `overrun=1`.
  - Repeat with `rd` coinciding with the second completion: `overrun=0`, `rda=1`.
- **Divisor edge:** `baud=0`, send 8'hFF then 8'h00 back-to-back.
  - Both bytes are received correctly, each with `rda`.
- **Reset mid-frame:** assert `rst_n=0` during bit 4 of 8'h5A, release, then send 8'h81.
  - All outputs read 0 during reset.
  - Next `rdata=8'h81`, with no error flags.

Source files
------------

// File: rtl/spart_rx_if.sv
// SPART receive port bundle: serial line, divisor and read strobe in, holding register out.
// parity_err exists only when SPART_RX_PARITY_EN is defined.
interface spart_rx_if #(
   parameter int DIV_W = 16
);
   logic             rxd;
   logic [DIV_W-1:0] baud;
   logic             rd;
   logic [7:0]       rdata;
   logic             rda;
   logic             framing_err;
   logic             overrun;
`ifdef SPART_RX_PARITY_EN
   logic             parity_err;

   modport master (
      output rxd, baud, rd,
      input  rdata, rda, framing_err, overrun, parity_err
   );
   modport slave (
      input  rxd, baud, rd,
      output rdata, rda, framing_err, overrun, parity_err
   );
`else
   modport master (
      output rxd, baud, rd,
      input  rdata, rda, framing_err, overrun
   );
   modport slave (
      input  rxd, baud, rd,
      output rdata, rda, framing_err, overrun
   );
`endif
endinterface

// File: rtl/spart_rx.sv
// SPART serial receiver: 8N1 LSB first, 16x oversampled, with holding register.
// Define SPART_RX_PARITY_EN for 8E1 framing with a sticky parity_err flag.
module spart_rx #(
   parameter int DIV_W = 16
) (
   input logic     clk,
   input logic     rst_n,
   spart_rx_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef SPART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t           state_q, state_d;
   logic             meta_q, rxs_q;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [3:0]       os_q, os_d;
   logic [2:0]       bi_q, bi_d;
   logic [7:0]       sh_q, sh_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             rda_q, rda_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic             tick;
   logic             done;
`ifdef SPART_RX_PARITY_EN
   logic             par_q, par_d;
   logic             perr_q, perr_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q  <= 1'b1;
         rxs_q   <= 1'b1;
         cnt_q   <= bus.baud;
         state_q <= S_IDLE;
         os_q    <= '0;
         bi_q    <= '0;
         sh_q    <= '0;
         rdata_q <= '0;
         rda_q   <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef SPART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         meta_q  <= bus.rxd;
         rxs_q   <= meta_q;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         os_q    <= os_d;
         bi_q    <= bi_d;
         sh_q    <= sh_d;
         rdata_q <= rdata_d;
         rda_q   <= rda_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
`ifdef SPART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   // baud is only sampled on reload, so a mid-count change waits its turn
   assign tick  = (cnt_q == '0);
   assign cnt_d = tick ? bus.baud : cnt_q - DIV_W'(1);

   always_comb begin
      state_d = state_q;
      os_d    = os_q;
      bi_d    = bi_q;
      sh_d    = sh_q;
      done    = 1'b0;
`ifdef SPART_RX_PARITY_EN
      par_d   = par_q;
`endif
      if (tick) begin
         unique case (state_q)
            S_IDLE: begin
               if (!rxs_q) begin
                  os_d    = '0;
                  state_d = S_START;
               end
            end
            S_START: begin
               if (os_q == 4'd7) begin
                  if (!rxs_q) begin
                     os_d    = '0;
                     bi_d    = '0;
                     state_d = S_DATA;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  os_d = os_q + 4'd1;
               end
            end
            S_DATA: begin
               os_d = os_q + 4'd1;
               if (os_q == 4'd15) begin
                  sh_d = {rxs_q, sh_q[7:1]};
                  if (bi_q == 3'd7) begin
`ifdef SPART_RX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end else begin
                     bi_d = bi_q + 3'd1;
                  end
               end
            end
`ifdef SPART_RX_PARITY_EN
            S_PARITY: begin
               os_d = os_q + 4'd1;
               if (os_q == 4'd15) begin
                  par_d   = rxs_q;
                  state_d = S_STOP;
               end
            end
`endif
            S_STOP: begin
               os_d = os_q + 4'd1;
               // leave at mid-stop so a back-to-back start edge is seen
               if (os_q == 4'd15) begin
                  done    = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      rda_d   = rda_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;
`ifdef SPART_RX_PARITY_EN
      perr_d  = perr_q;
`endif
      if (bus.rd && rda_q) begin
         rda_d  = 1'b0;
         ferr_d = 1'b0;
         ovr_d  = 1'b0;
`ifdef SPART_RX_PARITY_EN
         perr_d = 1'b0;
`endif
      end
      // a completing frame overrides a same-cycle read
      if (done) begin
         rdata_d = sh_q;
         rda_d   = 1'b1;
         if (!rxs_q) ferr_d = 1'b1;
         if (rda_q && !bus.rd) ovr_d = 1'b1;
`ifdef SPART_RX_PARITY_EN
         if (^{sh_q, par_q}) perr_d = 1'b1;
`endif
      end
   end

   assign bus.rdata       = rdata_q;
   assign bus.rda         = rda_q;
   assign bus.framing_err = ferr_q;
   assign bus.overrun     = ovr_q;
`ifdef SPART_RX_PARITY_EN
   assign bus.parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_spart_rx.sv
// Randomized self-checking bench for spart_rx against a frame-level model.
`timescale 1ns/1ps
module tb_spart_rx;
   localparam int DIV_W = 16;
`ifdef SPART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       stop_ok;
   } frame_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   frame_t     pend_q[$];
   logic [7:0] held = 8'h00;

   spart_rx_if #(.DIV_W(DIV_W)) bus ();
   spart_rx #(.DIV_W(DIV_W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   // frames received since the last accepted read decide every output
   function automatic logic [10:0] model_out();
      logic       f = 1'b0;
      logic [7:0] d = held;
      foreach (pend_q[i]) f |= ~pend_q[i].stop_ok;
      if (pend_q.size() > 0) d = pend_q[pend_q.size()-1].data;
      return {d, pend_q.size() > 0, f, pend_q.size() > 1};
   endfunction

   function automatic void model_rd();
      if (pend_q.size() > 0) held = pend_q[pend_q.size()-1].data;
      pend_q.delete();
   endfunction

   function automatic void model_reset();
      held = 8'h00;
      pend_q.delete();
   endfunction

   function automatic logic [10:0] obs();
      return {bus.rdata, bus.rda, bus.framing_err, bus.overrun};
   endfunction

   function automatic frame_t mk(input logic [7:0] d, input logic s);
      frame_t f;
      f.data    = d;
      f.stop_ok = s;
      return f;
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      int bl;
      bl = 16 * (int'(bus.baud) + 1);
      bus.rxd = 1'b0;
      repeat (bl) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.rxd = b[i];
         repeat (bl) @(negedge clk);
      end
`ifdef SPART_RX_PARITY_EN
      bus.rxd = ^b;
      repeat (bl) @(negedge clk);
`endif
      bus.rxd = stop_ok;
      repeat (bl) @(negedge clk);
      bus.rxd = 1'b1;
   endtask

   task automatic idle(input int n);
      bus.rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_rd();
      bus.rd = 1'b1;
      @(negedge clk);
      bus.rd = 1'b0;
   endtask

   task automatic test_reset();
      bus.rxd  = 1'b1;
      bus.rd   = 1'b0;
      bus.baud = 16'd3;
      rst_n    = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (obs() !== 11'h0) begin
         errors++;
         $display("FAIL reset_hold: got %h want %h", obs(), 11'h0);
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (obs() !== model_out()) begin
         errors++;
         $display("FAIL reset_release: got %h want %h", obs(), model_out());
      end
   endtask

   task automatic test_basic();
      int c;
      bus.baud = 16'd3;
      idle(100);
      c = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (!bus.rda && c < 1000) begin
               @(negedge clk);
               c++;
            end
         end
      join
      pend_q.push_back(mk(8'hA5, 1'b1));
      checks++;
      if (c < 600 || c > 625) begin
         errors++;
         $display("FAIL basic_latency: got %0d want 600..625", c);
      end
      checks++;
      if (obs() !== model_out()) begin
         errors++;
         $display("FAIL basic_byte: got %h want %h", obs(), model_out());
      end
      pulse_rd();
      model_rd();
      checks++;
      if (obs() !== model_out()) begin
         errors++;
         $display("FAIL basic_rd: got %h want %h", obs(), model_out());
      end
   endtask

   task automatic test_glitch();
      logic [7:0] d;
      bus.rxd = 1'b0;
      repeat (20) @(negedge clk);
      bus.rxd = 1'b1;
      repeat (300) @(negedge clk);
      checks++;
      if (obs() !== model_out()) begin
         errors++;
         $display("FAIL glitch_nobyte: got %h want %h", obs(), model_out());
      end
      d = 8'($urandom);
      send_frame(d, 1'b1);
      pend_q.push_back(mk(d, 1'b1));
      idle(64);
      checks++;
      if (obs() !== model_out()) begin
         errors++;
         $display("FAIL glitch_after: got %h want %h", obs(), model_out());
      end
      pulse_rd();
      model_rd();
   endtask

   task automatic test_framing();
      send_frame(8'h3C, 1'b0);
      pend_q.push_back(mk(8'h3C, 1'b0));
      idle(64);
      checks++;
      if (obs() !== model_out()) begin
         errors++;
         $display("FAIL framing_set: got %h want %h", obs(), model_out());
      end
      pulse_rd();
      model_rd();
      checks++;
      if (obs() !== model_out()) begin
         errors++;
         $display("FAIL framing_clr: got %h want %h", obs(), model_out());
      end
      idle(200);
   endtask

   task automatic test_overrun();
      int bl;
      int c1;
      bus.baud = 16'd3;
      bl = 64;
      idle(50);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      pend_q.push_back(mk(8'h11, 1'b1));
      pend_q.push_back(mk(8'h22, 1'b1));
      idle(64);
      checks++;
      if (obs() !== model_out()) begin
         errors++;
         $display("FAIL overrun_set: got %h want %h", obs(), model_out());
      end
      pulse_rd();
      model_rd();
      checks++;
      if (obs() !== model_out()) begin
         errors++;
         $display("FAIL overrun_clr: got %h want %h", obs(), model_out());
      end
      idle(50);
      c1 = 0;
      fork
         begin
            send_frame(8'h11, 1'b1);
            send_frame(8'h22, 1'b1);
         end
         begin
            while (!bus.rda && c1 < 1000) begin
               @(negedge clk);
               c1++;
            end
            // same tick phase on the second frame, so it completes NBITS*bl later
            repeat (NBITS * bl - 1) @(negedge clk);
            bus.rd = 1'b1;
            @(negedge clk);
            bus.rd = 1'b0;
         end
      join
      checks++;
      if (c1 >= 1000) begin
         errors++;
         $display("FAIL overrun_wait: got timeout want rda");
      end
      pend_q.push_back(mk(8'h11, 1'b1));
      model_rd();
      pend_q.push_back(mk(8'h22, 1'b1));
      idle(64);
      checks++;
      if (obs() !== model_out()) begin
         errors++;
         $display("FAIL overrun_rdwin: got %h want %h", obs(), model_out());
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b;
      b = 8'h5A;
      bus.rxd = 1'b0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.rxd = b[i];
         repeat (64) @(negedge clk);
      end
      bus.rxd = b[4];
      repeat (32) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs() !== 11'h0) begin
         errors++;
         $display("FAIL midrst_now: got %h want %h", obs(), 11'h0);
      end
      bus.rxd = 1'b1;
      repeat (5) @(negedge clk);
      model_reset();
      checks++;
      if (obs() !== model_out()) begin
         errors++;
         $display("FAIL midrst_hold: got %h want %h", obs(), model_out());
      end
      rst_n = 1'b1;
      idle(200);
      send_frame(8'h81, 1'b1);
      pend_q.push_back(mk(8'h81, 1'b1));
      idle(64);
      checks++;
      if (obs() !== model_out()) begin
         errors++;
         $display("FAIL midrst_next: got %h want %h", obs(), model_out());
      end
      pulse_rd();
      model_rd();
   endtask

   task automatic test_baud0();
      bit ok;
      bus.baud = 16'd0;
      idle(20);
      fork
         begin
            send_frame(8'hFF, 1'b1);
            send_frame(8'h00, 1'b1);
         end
         begin
            ok = 1'b0;
            for (int i = 0; i < 400 && !ok; i++) begin
               if (bus.rda) ok = 1'b1;
               else @(negedge clk);
            end
            pend_q.push_back(mk(8'hFF, 1'b1));
            checks++;
            if (obs() !== model_out()) begin
               errors++;
               $display("FAIL baud0_ff: got %h want %h", obs(), model_out());
            end
            pulse_rd();
            model_rd();
            ok = 1'b0;
            for (int i = 0; i < 400 && !ok; i++) begin
               if (bus.rda) ok = 1'b1;
               else @(negedge clk);
            end
            pend_q.push_back(mk(8'h00, 1'b1));
            checks++;
            if (obs() !== model_out()) begin
               errors++;
               $display("FAIL baud0_00: got %h want %h", obs(), model_out());
            end
         end
      join
      pulse_rd();
      model_rd();
   endtask

   task automatic test_random();
      int         n;
      int         bl;
      logic [7:0] d;
      logic       s;
      for (int it = 0; it < 6; it++) begin
         bus.baud = 16'($urandom_range(0, 3));
         idle(40);
         bl = 16 * (int'(bus.baud) + 1);
         n = $urandom_range(1, 2);
         for (int k = 0; k < n; k++) begin
            d = 8'($urandom);
            s = (k < n - 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            send_frame(d, s);
            pend_q.push_back(mk(d, s));
         end
         idle(bl);
         checks++;
         if (obs() !== model_out()) begin
            errors++;
            $display("FAIL rand_frame%0d: got %h want %h", it, obs(), model_out());
         end
`ifdef SPART_RX_PARITY_EN
         checks++;
         if (bus.parity_err !== 1'b0) begin
            errors++;
            $display("FAIL rand_parity%0d: got %b want 0", it, bus.parity_err);
         end
`endif
         pulse_rd();
         model_rd();
         checks++;
         if (obs() !== model_out()) begin
            errors++;
            $display("FAIL rand_rd%0d: got %h want %h", it, obs(), model_out());
         end
         idle(2 * bl);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_framing();
      test_overrun();
      test_reset_midframe();
      test_baud0();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
